// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parameterised UART receiver. The asynchronous serial line is brought into
// the clock domain through a two-flop synchronizer. A five-state FSM then
// finds the start bit on a falling edge, confirms it at mid-bit, and samples
// each data, parity and stop bit once per bit period, near mid-bit. Every
// completed frame, including one with errors, produces a one-cycle
// data_valid pulse together with the received word and its error flags.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (even, >= 4)
//   DATA_BITS    : data bits per frame (5..9)
//   PARITY       : 0 none, 1 even, 2 odd
//   STOP_BITS    : stop bits checked per frame (1 or 2)
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   rx_in      : asynchronous serial input, idle high
//   data_out   : last received word (first bit on the line is the LSB)
//   data_valid : one-cycle pulse when a frame completes
//   parity_err : parity mismatch of the last frame, qualified by data_valid
//   frame_err  : a stop bit of the last frame sampled low, qualified by data_valid
//   busy       : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_s_q, rx_s_d;
    logic                 rx_prev_q, rx_prev_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 pend_q, pend_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 fall;

    // Falling edge of the synchronized line. The edge register only becomes
    // 1 again once the line has actually been high, so a line held low after
    // a bad stop bit cannot start a new frame.
    assign fall = rx_prev_q & ~rx_s_q;

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        pend_d       = 1'b0;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        rx_meta_d    = rx_in;
        rx_s_d       = rx_meta_q;
        rx_prev_d    = rx_s_q;

        case (state_q)
            IDLE: begin
                cyc_d = '0;
                bit_d = '0;
                // pend_q carries an edge that arrived while the last stop bit
                // was being sampled, when the FSM could not yet act on it.
                if (fall || pend_q) begin
                    state_d = START;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end

            START: begin
                // Half a bit after the edge: still low means a real start bit.
                if (cyc_q == HALF_LAST) begin
                    cyc_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end

            DATA: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY == 0) ? STOP : PAR;
                    end
                end
            end

            PAR: begin
                // Mismatch when the received bit differs from the XOR of the
                // data (even) or its inverse (odd).
                if (cyc_q == BIT_LAST) begin
                    cyc_d   = '0;
                    perr_d  = rx_s_q ^ (^shift_q) ^ PAR_ODD;
                    state_d = STOP;
                end
            end

            STOP: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_d  = '0;
                    ferr_d = ferr_q | ~rx_s_q;
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == STOP_LAST) begin
                        bit_d        = '0;
                        state_d      = IDLE;
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                        parity_err_d = perr_q;
                        frame_err_d  = ferr_q | ~rx_s_q;
                        pend_d       = fall;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cyc_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cyc_q        <= '0;
            bit_q        <= '0;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            pend_q       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            bit_q        <= bit_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            rx_prev_q    <= rx_prev_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            pend_q       <= pend_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // The shift register is fully rewritten by every frame before it is
    // copied to data_out, so it needs no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Directed bench for uart_rx_param at CLKS_PER_BIT=4. Four instances cover
// 8N1, even parity, two stop bits and odd parity, each on its own serial line.
// A monitor records every data_valid pulse with the word and flags seen on it.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rx;
    logic [3:0] dv, pe, fe, bsy;
    logic [7:0] dout [4];

    int         vcnt [4];
    logic [7:0] hist [4][32];
    logic [3:0] last_pe, last_fe;
    int         checks;
    int         fails;

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .rx_in(rx[0]), .data_out(dout[0]),
        .data_valid(dv[0]), .parity_err(pe[0]), .frame_err(fe[0]), .busy(bsy[0]));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .rx_in(rx[1]), .data_out(dout[1]),
        .data_valid(dv[1]), .parity_err(pe[1]), .frame_err(fe[1]), .busy(bsy[1]));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .rx_in(rx[2]), .data_out(dout[2]),
        .data_valid(dv[2]), .parity_err(pe[2]), .frame_err(fe[2]), .busy(bsy[2]));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u3 (
        .clk(clk), .rst(rst), .rx_in(rx[3]), .data_out(dout[3]),
        .data_valid(dv[3]), .parity_err(pe[3]), .frame_err(fe[3]), .busy(bsy[3]));

    // Record each data_valid pulse; a pulse longer than one cycle is counted
    // more than once and shows up in the frame counts.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (dv[i]) begin
                if (vcnt[i] < 32) hist[i][vcnt[i]] <= dout[i];
                last_pe[i] <= pe[i];
                last_fe[i] <= fe[i];
                vcnt[i]    <= vcnt[i] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then step just past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_for(input int w, input logic b);
        rx[w] = b;
        tick(CPB);
    endtask

    // Start bit, 8 data bits LSB first, optional parity bit, then nstop stop
    // bits taken from stops[0], stops[1]. The line is left at the last stop value.
    task automatic send_frame(input int w, input logic [7:0] d, input bit has_par,
                              input logic pbit, input int nstop, input logic [1:0] stops);
        bit_for(w, 1'b0);
        for (int i = 0; i < 8; i++) bit_for(w, d[i]);
        if (has_par) bit_for(w, pbit);
        for (int s = 0; s < nstop; s++) bit_for(w, stops[s]);
    endtask

    task automatic idle(input int w, input int n);
        rx[w] = 1'b1;
        tick(n);
    endtask

    initial begin
        int b;
        int n;
        int m;
        checks = 0;
        fails  = 0;
        rx     = 4'hF;
        rst    = 1'b1;
        tick(3);

        // Reset state
        chk("rst_data_out", 32'(dout[0]), 32'h0);
        chk("rst_valid", 32'(dv), 32'h0);
        chk("rst_parity_err", 32'(pe), 32'h0);
        chk("rst_frame_err", 32'(fe), 32'h0);
        chk("rst_busy", 32'(bsy), 32'h0);
        rst = 1'b0;
        tick(4);

        // 8N1 frame 0xA5
        b = vcnt[0];
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 2'b11);
        idle(0, 8);
        chk("s1_count", 32'(vcnt[0]), 32'(b + 1));
        chk("s1_data", 32'(hist[0][b]), 32'hA5);
        chk("s1_perr", 32'(last_pe[0]), 32'h0);
        chk("s1_ferr", 32'(last_fe[0]), 32'h0);
        chk("s1_busy", 32'(bsy[0]), 32'h0);
        chk("s1_hold", 32'(dout[0]), 32'hA5);

        // Even parity: 0x07 has three ones, so the correct parity bit is 1
        b = vcnt[1];
        send_frame(1, 8'h07, 1'b1, 1'b0, 1, 2'b11);
        idle(1, 8);
        chk("s2a_count", 32'(vcnt[1]), 32'(b + 1));
        chk("s2a_data", 32'(hist[1][b]), 32'h07);
        chk("s2a_perr", 32'(last_pe[1]), 32'h1);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1, 2'b11);
        idle(1, 8);
        chk("s2b_count", 32'(vcnt[1]), 32'(b + 2));
        chk("s2b_data", 32'(hist[1][b + 1]), 32'h07);
        chk("s2b_perr", 32'(last_pe[1]), 32'h0);

        // Odd parity: 0x07 wants bit 0, 0x06 (two ones) wants bit 1
        b = vcnt[3];
        send_frame(3, 8'h07, 1'b1, 1'b0, 1, 2'b11);
        idle(3, 8);
        chk("odd_a_perr", 32'(last_pe[3]), 32'h0);
        send_frame(3, 8'h06, 1'b1, 1'b0, 1, 2'b11);
        idle(3, 8);
        chk("odd_b_count", 32'(vcnt[3]), 32'(b + 2));
        chk("odd_b_data", 32'(hist[3][b + 1]), 32'h06);
        chk("odd_b_perr", 32'(last_pe[3]), 32'h1);

        // Two stop bits, second one low; the line then stays low
        b = vcnt[2];
        send_frame(2, 8'h3C, 1'b0, 1'b0, 2, 2'b01);
        tick(24);
        chk("s3a_count", 32'(vcnt[2]), 32'(b + 1));
        chk("s3a_data", 32'(hist[2][b]), 32'h3C);
        chk("s3a_ferr", 32'(last_fe[2]), 32'h1);
        chk("s3_low_busy", 32'(bsy[2]), 32'h0);
        chk("s3_low_hold_ferr", 32'(fe[2]), 32'h1);
        idle(2, 8);
        send_frame(2, 8'h3C, 1'b0, 1'b0, 2, 2'b11);
        idle(2, 8);
        chk("s3b_count", 32'(vcnt[2]), 32'(b + 2));
        chk("s3b_data", 32'(hist[2][b + 1]), 32'h3C);
        chk("s3b_ferr", 32'(last_fe[2]), 32'h0);

        // One-cycle glitch low
        b = vcnt[0];
        rx[0] = 1'b0;
        tick(1);
        rx[0] = 1'b1;
        n = 0;
        while (!bsy[0] && n < 8) begin
            tick(1);
            n++;
        end
        chk("s4_busy_rise", 32'(bsy[0]), 32'h1);
        m = 0;
        while (bsy[0] && m < 20) begin
            tick(1);
            m++;
        end
        chk("s4_busy_fall_in_time", 32'(m <= CPB / 2 + 3), 32'h1);
        idle(0, 4 * CPB);
        chk("s4_no_valid", 32'(vcnt[0]), 32'(b));

        // Reset during data bit 3 of 0xFF
        b = vcnt[0];
        bit_for(0, 1'b0);
        for (int i = 0; i < 3; i++) bit_for(0, 1'b1);
        rx[0] = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(2);
        chk("s5_busy", 32'(bsy[0]), 32'h0);
        chk("s5_data_out", 32'(dout[0]), 32'h0);
        chk("s5_valid", 32'(dv[0]), 32'h0);
        rst = 1'b0;
        idle(0, 12 * CPB);
        chk("s5_no_valid", 32'(vcnt[0]), 32'(b));
        chk("s5_flags", 32'({pe[0], fe[0]}), 32'h0);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1, 2'b11);
        idle(0, 8);
        chk("s5_after_count", 32'(vcnt[0]), 32'(b + 1));
        chk("s5_after_data", 32'(hist[0][b]), 32'h12);

        // Back-to-back frames, no idle gap
        b = vcnt[0];
        send_frame(0, 8'h55, 1'b0, 1'b0, 1, 2'b11);
        send_frame(0, 8'hAA, 1'b0, 1'b0, 1, 2'b11);
        idle(0, 8);
        chk("s6_count", 32'(vcnt[0]), 32'(b + 2));
        chk("s6_first", 32'(hist[0][b]), 32'h55);
        chk("s6_second", 32'(hist[0][b + 1]), 32'hAA);
        chk("s6_ferr", 32'(last_fe[0]), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
